// File: rtl/rv32_rvfi_monitor.sv
// RVFI retirement monitor: order/PC-chain/x0/mem-mask/alignment checks, instret count, first-error latch, trace FIFO.
// Latency: counters, error state and an empty-FIFO trace head all reflect a packet one cycle after it is sampled.
// Backpressure: none toward RVFI; a trace record arriving at a full FIFO with no pop is dropped and flagged.
//
// Ports: clk/reset (async, active-low); rvfi_* retirement packet; clear_in synchronous clear;
//        trace_valid/trace_ready handshake with trace_pc/trace_insn/trace_trap head record;
//        instret_out, error_out/error_code_out/error_order_out, overflow_out status.
module rv32_rvfi_monitor #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rvfi_valid,
    input  logic [63:0] rvfi_order,
    input  logic [31:0] rvfi_insn,
    input  logic        rvfi_trap,
    input  logic        rvfi_intr,
    input  logic [4:0]  rvfi_rd_addr,
    input  logic [31:0] rvfi_rd_wdata,
    input  logic [31:0] rvfi_pc_rdata,
    input  logic [31:0] rvfi_pc_wdata,
    input  logic [3:0]  rvfi_mem_rmask,
    input  logic [3:0]  rvfi_mem_wmask,
    input  logic        clear_in,
    input  logic        trace_ready,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_insn,
    output logic        trace_trap,
    output logic [63:0] instret_out,
    output logic        error_out,
    output logic [2:0]  error_code_out,
    output logic [63:0] error_order_out,
    output logic        overflow_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        trap;
    } trace_rec_t;

    logic            have_prev_q,     have_prev_d;
    logic [63:0]     prev_order_q,    prev_order_d;
    logic [31:0]     prev_pc_wdata_q, prev_pc_wdata_d;
    logic            prev_trap_q,     prev_trap_d;
    logic [63:0]     instret_q,       instret_d;
    logic            err_q,           err_d;
    logic [2:0]      err_code_q,      err_code_d;
    logic [63:0]     err_order_q,     err_order_d;
    logic            ovf_q,           ovf_d;
    logic [PW-1:0]   wptr_q,          wptr_d;
    logic [PW-1:0]   rptr_q,          rptr_d;
    trace_rec_t      mem_q [FIFO_DEPTH];
    trace_rec_t      mem_d [FIFO_DEPTH];

    logic            accept, empty, full, pop, push;
    logic [2:0]      code;
    trace_rec_t      head;

    assign accept = rvfi_valid && !clear_in;
    assign empty  = (wptr_q == rptr_q);
    // Same index, opposite lap bit: writer is a full lap ahead.
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop    = !empty && trace_ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign push   = accept && (!full || pop);

    // Lowest failing code wins, so test in ascending order.
    always_comb begin
        code = 3'd0;
        if (have_prev_q && (rvfi_order != prev_order_q + 64'd1))
            code = 3'd1;
        else if (have_prev_q && !rvfi_intr && !prev_trap_q && (rvfi_pc_rdata != prev_pc_wdata_q))
            code = 3'd2;
        else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0))
            code = 3'd3;
        else if ((rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0))
            code = 3'd4;
        else if (!rvfi_trap && (rvfi_pc_wdata[1:0] != 2'b00))
            code = 3'd5;
    end

    always_comb begin
        have_prev_d     = have_prev_q;
        prev_order_d    = prev_order_q;
        prev_pc_wdata_d = prev_pc_wdata_q;
        prev_trap_d     = prev_trap_q;
        instret_d       = instret_q;
        err_d           = err_q;
        err_code_d      = err_code_q;
        err_order_d     = err_order_q;
        ovf_d           = ovf_q;
        wptr_d          = wptr_q;
        rptr_d          = rptr_q;
        mem_d           = mem_q;
        if (clear_in) begin
            have_prev_d     = 1'b0;
            prev_order_d    = 64'd0;
            prev_pc_wdata_d = 32'd0;
            prev_trap_d     = 1'b0;
            instret_d       = 64'd0;
            err_d           = 1'b0;
            err_code_d      = 3'd0;
            err_order_d     = 64'd0;
            ovf_d           = 1'b0;
            wptr_d          = '0;
            rptr_d          = '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = '0;
        end else begin
            if (accept) begin
                have_prev_d     = 1'b1;
                prev_order_d    = rvfi_order;
                prev_pc_wdata_d = rvfi_pc_wdata;
                prev_trap_d     = rvfi_trap;
                if (!rvfi_trap) instret_d = instret_q + 64'd1;
                if (!err_q && (code != 3'd0)) begin
                    err_d       = 1'b1;
                    err_code_d  = code;
                    err_order_d = rvfi_order;
                end
                if (!push) ovf_d = 1'b1;
            end
            if (pop) rptr_d = rptr_q + PW'(1);
            if (push) begin
                mem_d[wptr_q[AW-1:0]] = '{pc: rvfi_pc_rdata, insn: rvfi_insn, trap: rvfi_trap};
                wptr_d = wptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            have_prev_q     <= 1'b0;
            prev_order_q    <= 64'd0;
            prev_pc_wdata_q <= 32'd0;
            prev_trap_q     <= 1'b0;
            instret_q       <= 64'd0;
            err_q           <= 1'b0;
            err_code_q      <= 3'd0;
            err_order_q     <= 64'd0;
            ovf_q           <= 1'b0;
            wptr_q          <= '0;
            rptr_q          <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            have_prev_q     <= have_prev_d;
            prev_order_q    <= prev_order_d;
            prev_pc_wdata_q <= prev_pc_wdata_d;
            prev_trap_q     <= prev_trap_d;
            instret_q       <= instret_d;
            err_q           <= err_d;
            err_code_q      <= err_code_d;
            err_order_q     <= err_order_d;
            ovf_q           <= ovf_d;
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign head            = mem_q[rptr_q[AW-1:0]];
    assign trace_valid     = !empty;
    assign trace_pc        = head.pc;
    assign trace_insn      = head.insn;
    assign trace_trap      = head.trap;
    assign instret_out     = instret_q;
    assign error_out       = err_q;
    assign error_code_out  = err_code_q;
    assign error_order_out = err_order_q;
    assign overflow_out    = ovf_q;
endmodule
